// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA/SVGA raster timing generator with a two-stage enabled pipeline.
//
// Stage 0 holds the raster counters (hpos/vpos) and presents the tile fetch address
// (tile_x/tile_y). Stage 1 delays the counters by one enabled edge while the pixel
// source looks up the fetch address. The output registers then sample pixel_in together
// with the delayed position. Sync, blank and colour therefore change on the second
// enabled edge after the counter value, and they stay mutually aligned.
//
// Ports:
//   pixel_clk    single clock
//   rst          asynchronous active-high reset
//   pix_en       pixel advance strobe; all state holds when low
//   pixel_in     {r,g,b} returned one enabled cycle after the fetch address
//   pattern_sel  test-pattern select (used only with VGA_TIMING_TESTPAT_EN)
//   hpos/vpos    stage-0 counters
//   tile_x/y     counters shifted right by TILE_SHIFT (combinational)
//   hsync/vsync  registered syncs; polarity set by HSYNC_POS/VSYNC_POS
//   blank        registered, active high; forces colour to 0
//   vr/vg/vb     registered colour
//   frame_start  registered one-cycle pulse for output position (0,0)
//   line_start   registered one-cycle pulse for output position (0,y), y < V_ACTIVE
//
// Optional feature: define VGA_TIMING_TESTPAT_EN to build in the test-pattern generator.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 64,
  parameter int unsigned H_SYNC     = 136,
  parameter int unsigned H_BP       = 200,
  parameter int unsigned V_ACTIVE   = 800,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_BP       = 24,
  parameter int unsigned HSYNC_POS  = 0,
  parameter int unsigned VSYNC_POS  = 1,
  parameter int unsigned COLOR_W    = 5,
  parameter int unsigned TILE_SHIFT = 3
) (
  input  logic                   pixel_clk,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic [3*COLOR_W-1:0]   pixel_in,
  input  logic [1:0]             pattern_sel,
  output logic [11:0]            hpos,
  output logic [10:0]            vpos,
  output logic [11-TILE_SHIFT:0] tile_x,
  output logic [10-TILE_SHIFT:0] tile_y,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   blank,
  output logic [COLOR_W-1:0]     vr,
  output logic [COLOR_W-1:0]     vg,
  output logic [COLOR_W-1:0]     vb,
  output logic                   frame_start,
  output logic                   line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_total_err
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds counter range");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      COLOR_W == 0 || TILE_SHIFT == 0) begin : g_zero_err
    $error("vga_timing_gen: timing and width parameters must be non-zero");
  end

  localparam logic [11:0] HLast     = 12'(H_TOTAL - 1);
  localparam logic [11:0] HAct      = 12'(H_ACTIVE);
  localparam logic [11:0] HSyncBeg  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HSyncEnd  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VLast     = 11'(V_TOTAL - 1);
  localparam logic [10:0] VAct      = 11'(V_ACTIVE);
  localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic        HSyncOn   = (HSYNC_POS != 0);
  localparam logic        VSyncOn   = (VSYNC_POS != 0);

  // Stage 0: raster counters
  logic [11:0] r_hpos;
  logic [10:0] r_vpos;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else if (pix_en) begin
      if (r_hpos == HLast) begin
        r_hpos <= '0;
        r_vpos <= (r_vpos == VLast) ? '0 : r_vpos + 11'd1;
      end else begin
        r_hpos <= r_hpos + 12'd1;
      end
    end
  end

  assign hpos   = r_hpos;
  assign vpos   = r_vpos;
  // Dropping the low bits is the shift right by TILE_SHIFT.
  assign tile_x = r_hpos[11:TILE_SHIFT];
  assign tile_y = r_vpos[10:TILE_SHIFT];

  // Stage 1: delayed counters. r_vld1 marks that the delay registers hold a real
  // position. It keeps the first edge after reset from emitting a frame_start or a sync.
  logic [11:0] r_h1;
  logic [10:0] r_v1;
  logic        r_vld1;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_h1   <= '0;
      r_v1   <= '0;
      r_vld1 <= 1'b0;
    end else if (pix_en) begin
      r_h1   <= r_hpos;
      r_v1   <= r_vpos;
      r_vld1 <= 1'b1;
    end
  end

  // Next output values, decoded from the delayed position
  logic                 w_hs_act;
  logic                 w_vs_act;
  logic                 w_blank;
  logic                 w_h_zero;
  logic [COLOR_W-1:0]   w_r;
  logic [COLOR_W-1:0]   w_g;
  logic [COLOR_W-1:0]   w_b;

  assign w_hs_act = r_vld1 && (r_h1 >= HSyncBeg) && (r_h1 <= HSyncEnd);
  assign w_vs_act = r_vld1 && (r_v1 >= VSyncBeg) && (r_v1 <= VSyncEnd);
  assign w_blank  = !r_vld1 || (r_h1 >= HAct) || (r_v1 >= VAct);
  assign w_h_zero = r_vld1 && (r_h1 == 12'd0);

`ifdef VGA_TIMING_TESTPAT_EN
  if (COLOR_W + 4 > 11) begin : g_pat_err
    $error("vga_timing_gen: COLOR_W too wide for the test pattern");
  end

  always_comb begin
    w_r = pixel_in[3*COLOR_W-1:2*COLOR_W];
    w_g = pixel_in[2*COLOR_W-1:COLOR_W];
    w_b = pixel_in[COLOR_W-1:0];
    unique case (pattern_sel)
      2'd1: begin
        w_r = r_v1[COLOR_W+3:4];
        w_g = r_h1[COLOR_W+3:4];
        w_b = '0;
      end
      2'd2: begin
        w_r = r_v1[COLOR_W+3:4];
        w_g = '0;
        w_b = r_h1[COLOR_W+3:4];
      end
      2'd3: begin
        w_r = '1;
        w_g = '1;
        w_b = '1;
      end
      default: ;
    endcase
  end
`else
  logic w_unused_pattern_sel;
  assign w_unused_pattern_sel = ^pattern_sel;

  assign w_r = pixel_in[3*COLOR_W-1:2*COLOR_W];
  assign w_g = pixel_in[2*COLOR_W-1:COLOR_W];
  assign w_b = pixel_in[COLOR_W-1:0];
`endif

  // Output registers
  logic               r_hsync;
  logic               r_vsync;
  logic               r_blank;
  logic [COLOR_W-1:0] r_vr;
  logic [COLOR_W-1:0] r_vg;
  logic [COLOR_W-1:0] r_vb;
  logic               r_frame_start;
  logic               r_line_start;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_hsync       <= !HSyncOn;
      r_vsync       <= !VSyncOn;
      r_blank       <= 1'b1;
      r_vr          <= '0;
      r_vg          <= '0;
      r_vb          <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      // Pulses last one clock even when the next edge is disabled.
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      if (pix_en) begin
        r_hsync       <= w_hs_act ? HSyncOn : !HSyncOn;
        r_vsync       <= w_vs_act ? VSyncOn : !VSyncOn;
        r_blank       <= w_blank;
        r_vr          <= w_blank ? '0 : w_r;
        r_vg          <= w_blank ? '0 : w_g;
        r_vb          <= w_blank ? '0 : w_b;
        r_frame_start <= w_h_zero && (r_v1 == 11'd0);
        r_line_start  <= w_h_zero && (r_v1 < VAct);
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign vr          = r_vr;
  assign vg          = r_vg;
  assign vb          = r_vb;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen with a small raster (32 x 18). A position-indexed
// pixel RAM feeds pixel_in with one enabled cycle of latency. The reference model
// counts enabled edges since reset and derives every expected output arithmetically.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 10, VF = 2, VS = 3, VB = 3;
  localparam int CW = 5, TS = 2;
  localparam int HT = HA + HF + HS + HB;  // 32
  localparam int VT = VA + VF + VS + VB;  // 18
  localparam int FR = HT * VT;            // 576

  logic              pixel_clk;
  logic              rst;
  logic              pix_en;
  logic [3*CW-1:0]   pixel_in;
  logic [1:0]        pattern_sel;
  logic [11:0]       hpos;
  logic [10:0]       vpos;
  logic [11-TS:0]    tile_x;
  logic [10-TS:0]    tile_y;
  logic              hsync, vsync, blank;
  logic [CW-1:0]     vr, vg, vb;
  logic              frame_start, line_start;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POS(0), .VSYNC_POS(1), .COLOR_W(CW), .TILE_SHIFT(TS)
  ) u_dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .pixel_in    (pixel_in),
    .pattern_sel (pattern_sel),
    .hpos        (hpos),
    .vpos        (vpos),
    .tile_x      (tile_x),
    .tile_y      (tile_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .vr          (vr),
    .vg          (vg),
    .vb          (vb),
    .frame_start (frame_start),
    .line_start  (line_start)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  logic [3*CW-1:0] lut [FR];
  int  n_en;      // enabled edges since reset release
  bit  last_en;   // was the most recent edge enabled
  int  nvec;
  int  nerr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40)
        $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: outputs after n_en enabled edges reflect raster position n_en-2.
  task automatic check_model();
    int p, eh, ev, q, h, v;
    bit ehs, evs, eb, efs, els;
    logic [3*CW-1:0] ecol;
    p  = n_en % FR;
    eh = p % HT;
    ev = p / HT;
    chk("hpos", 32'(hpos), 32'(eh));
    chk("vpos", 32'(vpos), 32'(ev));
    chk("tile_x", 32'(tile_x), 32'(eh >> TS));
    chk("tile_y", 32'(tile_y), 32'(ev >> TS));
    ehs = 1'b1; evs = 1'b0; eb = 1'b1; efs = 1'b0; els = 1'b0; ecol = '0;
    if (n_en >= 2) begin
      q   = (n_en - 2) % FR;
      h   = q % HT;
      v   = q / HT;
      ehs = !(h >= HA + HF && h < HA + HF + HS);
      evs = (v >= VA + VF && v < VA + VF + VS);
      eb  = (h >= HA) || (v >= VA);
      ecol = eb ? '0 : lut[q];
      efs = last_en && h == 0 && v == 0;
      els = last_en && h == 0 && v < VA;
    end
    chk("hsync", 32'(hsync), 32'(ehs));
    chk("vsync", 32'(vsync), 32'(evs));
    chk("blank", 32'(blank), 32'(eb));
    chk("colour", 32'({vr, vg, vb}), 32'(ecol));
    chk("frame_start", 32'(frame_start), 32'(efs));
    chk("line_start", 32'(line_start), 32'(els));
  endtask

  // One clock: drive inputs, take the edge, update the RAM model and check.
  task automatic step(input bit en);
    int addr;
    pix_en      = en;
    pattern_sel = 2'($urandom);
    addr        = int'(vpos) * HT + int'(hpos);
    @(posedge pixel_clk);
    #1;
    if (en) begin
      if (addr < FR) pixel_in = lut[addr];
      n_en++;
    end
    last_en = en;
    check_model();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    n_en    = 0;
    last_en = 1'b0;
    check_model();  // reset acts asynchronously
    repeat (cycles) @(posedge pixel_clk);
    #1;
    check_model();
    rst = 1'b0;
  endtask

  typedef struct {
    bit en;
    int exp_hpos;
    bit exp_hsync;
    bit exp_blank;
    bit exp_fs;
    bit exp_ls;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int fs_first, fs_second, hs_low, fs_run, fs_max, k;
    nvec = 0; nerr = 0;
    rst = 1'b0; pix_en = 1'b0; pixel_in = '0; pattern_sel = '0;
    n_en = 0; last_en = 1'b0;
    for (int i = 0; i < FR; i++) lut[i] = 15'($urandom);

    tbl[0] = '{1, 1, 1, 1, 0, 0};
    tbl[1] = '{1, 2, 1, 0, 1, 1};
    tbl[2] = '{0, 2, 1, 0, 0, 0};
    tbl[3] = '{1, 3, 1, 0, 0, 0};
    tbl[4] = '{0, 3, 1, 0, 0, 0};
    tbl[5] = '{1, 4, 1, 0, 0, 0};

    #2;
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].en);
      chk("tbl_hpos", 32'(hpos), 32'(tbl[i].exp_hpos));
      chk("tbl_hsync", 32'(hsync), 32'(tbl[i].exp_hsync));
      chk("tbl_blank", 32'(blank), 32'(tbl[i].exp_blank));
      chk("tbl_frame_start", 32'(frame_start), 32'(tbl[i].exp_fs));
      chk("tbl_line_start", 32'(line_start), 32'(tbl[i].exp_ls));
    end

    // Continuous enable: frame period and hsync low time over one frame.
    do_reset(1);
    fs_first = -1; fs_second = -1; hs_low = 0;
    for (int i = 0; i < 3 * FR && fs_second < 0; i++) begin
      step(1'b1);
      if (fs_first >= 0 && hsync == 1'b0) hs_low++;
      if (frame_start) begin
        if (fs_first < 0) fs_first = i;
        else fs_second = i;
      end
    end
    chk("first_fs_after_release", 32'(fs_first), 32'd1);
    chk("frame_period", 32'(fs_second - fs_first), 32'(FR));
    chk("hsync_low_per_frame", 32'(hs_low), 32'(HS * VT));

    // Toggling enable: period doubles, frame_start stays one clock wide.
    do_reset(1);
    fs_first = -1; fs_second = -1; fs_run = 0; fs_max = 0;
    for (int i = 0; i < 5 * FR && fs_second < 0; i++) begin
      step(i % 2 == 0);
      if (frame_start) begin
        fs_run++;
        if (fs_run > fs_max) fs_max = fs_run;
        if (fs_first < 0) fs_first = i;
        else fs_second = i;
      end else begin
        fs_run = 0;
      end
    end
    chk("toggle_frame_period", 32'(fs_second - fs_first), 32'(2 * FR));
    chk("toggle_fs_width", 32'(fs_max), 32'd1);

    // Random enable pattern.
    for (int i = 0; i < 2500; i++) step($urandom_range(99) < 70);

    // Mid-frame reset at (20,5), then the first frame_start on the second enabled edge.
    k = 0;
    while ((n_en % FR) != 5 * HT + 20 && k < 2 * FR) begin
      step(1'b1);
      k++;
    end
    chk("reached_midframe", 32'(n_en % FR), 32'(5 * HT + 20));
    do_reset(3);
    step(1'b1);
    chk("post_reset_fs1", 32'(frame_start), 32'd0);
    step(1'b1);
    chk("post_reset_fs2", 32'(frame_start), 32'd1);
    for (int i = 0; i < 300; i++) step($urandom_range(1) == 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
